// File: rtl/conv3x3_if.sv
// conv3x3_if: window/kernel input handshake and result output handshake for conv3x3_engine.
interface conv3x3_if;
    logic                in_valid;
    logic                in_ready;
    logic [8:0][7:0]     pix_in;
    logic [8:0][7:0]     kernel_in;
    logic [1:0]          kernel_sel;
    logic                out_valid;
    logic                out_ready;
    logic [7:0]          pix_out;
    logic signed [19:0]  acc_out;
    modport master (
        output in_valid, pix_in, kernel_in, kernel_sel, out_ready,
        input  in_ready, out_valid, pix_out, acc_out
    );
    modport slave (
        input  in_valid, pix_in, kernel_in, kernel_sel, out_ready,
        output in_ready, out_valid, pix_out, acc_out
    );
endinterface

// File: rtl/conv3x3_engine.sv
// conv3x3_engine: sequential 3x3 multiply-accumulate, one tap per cycle, followed by
// a mode-dependent post-process (Sobel magnitude, sharpen clamp, box-blur divide by 9).
module conv3x3_engine (
    input  logic       clk,
    input  logic       rst_n,
    conv3x3_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, MAC, POST, OUT} state_t;
    state_t             state_q, state_d;
    logic [8:0][7:0]    pix_q, pix_d;
    logic [8:0][7:0]    kern_q, kern_d;
    logic [1:0]         sel_q, sel_d;
    logic signed [19:0] acc_q, acc_d;
    logic [3:0]         idx_q, idx_d;
    logic [7:0]         pix_out_q, pix_out_d;
    logic signed [19:0] acc_out_q, acc_out_d;
    logic               accept;
    logic signed [16:0] prod;
    logic [19:0]        mag;
    logic [7:0]         sobel_pix, sharp_pix, blur_pix, mode_pix;
    logic [11:0]        blur_c;
    logic [24:0]        blur_p;

    assign accept = bus.in_valid && state_q == IDLE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            pix_q     <= '0;
            kern_q    <= '0;
            sel_q     <= '0;
            acc_q     <= '0;
            idx_q     <= '0;
            pix_out_q <= '0;
            acc_out_q <= '0;
        end else begin
            state_q   <= state_d;
            pix_q     <= pix_d;
            kern_q    <= kern_d;
            sel_q     <= sel_d;
            acc_q     <= acc_d;
            idx_q     <= idx_d;
            pix_out_q <= pix_out_d;
            acc_out_q <= acc_out_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = accept ? MAC : IDLE;
            MAC:     state_d = idx_q == 4'd8 ? POST : MAC;
            POST:    state_d = OUT;
            default: state_d = bus.out_ready ? IDLE : OUT;
        endcase
    end

    always_comb begin
        bus.in_ready  = state_q == IDLE;
        bus.out_valid = state_q == OUT;
        bus.pix_out   = pix_out_q;
        bus.acc_out   = acc_out_q;
    end

    // Window and kernel shift down one tap per MAC edge, so tap idx always sits in slot 0.
    always_comb begin
        prod = 17'($signed({1'b0, pix_q[0]})) * 17'($signed(kern_q[0]));
    end

    always_comb begin
        mag       = acc_q[19] ? 20'(-acc_q) : acc_q;
        sobel_pix = mag > 20'd255 ? 8'd255 : mag[7:0];
        sharp_pix = acc_q[19] ? 8'd0 : (acc_q > 20'sd255 ? 8'd255 : acc_q[7:0]);
        blur_c    = acc_q[19] ? 12'd0 : (acc_q > 20'sd2295 ? 12'd2295 : acc_q[11:0]);
        blur_p    = 25'(blur_c) * 25'd7282;
        blur_pix  = blur_p[23:16];
        mode_pix  = sel_q == 2'd3 ? blur_pix : (sel_q == 2'd2 ? sharp_pix : sobel_pix);
    end

    always_comb begin
        pix_d     = pix_q;
        kern_d    = kern_q;
        sel_d     = sel_q;
        acc_d     = acc_q;
        idx_d     = idx_q;
        pix_out_d = pix_out_q;
        acc_out_d = acc_out_q;
        if (accept) begin
            pix_d  = bus.pix_in;
            kern_d = bus.kernel_in;
            sel_d  = bus.kernel_sel;
            acc_d  = '0;
            idx_d  = '0;
        end else if (state_q == MAC) begin
            acc_d  = acc_q + 20'(prod);
            idx_d  = idx_q + 4'd1;
            pix_d  = {8'd0, pix_q[8:1]};
            kern_d = {8'd0, kern_q[8:1]};
        end else if (state_q == POST) begin
            acc_out_d = acc_q;
            pix_out_d = mode_pix;
        end
    end
endmodule
